// File: rtl/sat_pkg.sv
// sat_pkg: shared collector state, default widths and reduction helpers
package sat_pkg;
    localparam int DEF_WIDTH_LVL = 16;
    localparam int DEF_WIDTH_CID = 3;
    localparam int MAX_C = 64;
    typedef logic [DEF_WIDTH_LVL-1:0] lvl_t;
    typedef enum logic [1:0] {IDLE, SCAN, EMIT} cc_state_e;
    function automatic logic [6:0] popcount(input logic [MAX_C-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < MAX_C; i++) n = n + {6'd0, v[i]};
        return n;
    endfunction
endpackage

// File: rtl/conflict_collector_if.sv
// conflict_collector_if: valid/ready stream of conflicting clause id and level
interface conflict_collector_if #(
    parameter int WIDTH_CID = 3,
    parameter int WIDTH_LVL = 16
);
    logic valid;
    logic ready;
    logic [WIDTH_CID-1:0] cid;
    logic [WIDTH_LVL-1:0] lvl;
    modport master(output valid, cid, lvl, input ready);
    modport slave(input valid, cid, lvl, output ready);
endinterface

// File: rtl/prio_enc_lsb.sv
// prio_enc_lsb: index of the lowest set bit plus a found flag
module prio_enc_lsb #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);
    always_comb begin
        idx_o = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--)
            if (vec_i[i]) begin
                idx_o = W'(i);
                found_o = 1'b1;
            end
    end
endmodule

// File: rtl/conflict_collector.sv
// conflict_collector: snapshots clause terminal outputs and streams conflicts in cid order
module conflict_collector
    import sat_pkg::*;
#(
    parameter int NUM_C = 8,
    parameter int WIDTH_CID = DEF_WIDTH_CID,
    parameter int WIDTH_LVL = DEF_WIDTH_LVL
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [NUM_C-1:0]           conflict_c_vec_i,
    input  logic [NUM_C-1:0]           imp_vec_i,
    input  logic [NUM_C-1:0]           csat_vec_i,
    input  logic [NUM_C*WIDTH_LVL-1:0] cmax_lvl_flat_i,
    conflict_collector_if.master       conf,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       conflict_o,
    output logic [WIDTH_CID:0]         conflict_cnt_o,
    output logic [WIDTH_LVL-1:0]       max_conf_lvl_o,
    output logic                       all_sat_o,
    output logic                       imp_any_o
);
    cc_state_e state_q, state_d;
    logic [NUM_C-1:0] pend_q, pend_d;
    logic [NUM_C*WIDTH_LVL-1:0] lvls_q, lvls_d;
    logic valid_q, valid_d, done_q, done_d;
    logic [WIDTH_CID-1:0] cid_q, cid_d, k;
    logic [WIDTH_LVL-1:0] olvl_q, olvl_d, max_q, max_d, snap_max, l;
    logic conflict_q, conflict_d, all_sat_q, all_sat_d, imp_any_q, imp_any_d, found;
    logic [WIDTH_CID:0] cnt_q, cnt_d;

    prio_enc_lsb #(.N(NUM_C), .W(WIDTH_CID)) u_pe (.vec_i(pend_q), .idx_o(k), .found_o(found));

    always_comb begin
        snap_max = '0;
        l = '0;
        // strict compare keeps the lowest cid on equal levels
        for (int i = 0; i < NUM_C; i++) begin
            l = cmax_lvl_flat_i[i*WIDTH_LVL +: WIDTH_LVL];
            if (conflict_c_vec_i[i] && l > snap_max) snap_max = l;
        end
        state_d = state_q;
        pend_d = pend_q;
        lvls_d = lvls_q;
        valid_d = valid_q;
        cid_d = cid_q;
        olvl_d = olvl_q;
        done_d = 1'b0;
        conflict_d = conflict_q;
        cnt_d = cnt_q;
        max_d = max_q;
        all_sat_d = all_sat_q;
        imp_any_d = imp_any_q;
        if (state_q == IDLE && start_i) begin
            pend_d = conflict_c_vec_i;
            lvls_d = cmax_lvl_flat_i;
            conflict_d = |conflict_c_vec_i;
            cnt_d = (WIDTH_CID+1)'(popcount(MAX_C'(conflict_c_vec_i)));
            max_d = snap_max;
            all_sat_d = &csat_vec_i;
            imp_any_d = |imp_vec_i;
            state_d = SCAN;
        end
        if (state_q == SCAN) begin
            valid_d = found;
            cid_d = found ? k : cid_q;
            olvl_d = found ? lvls_q[k*WIDTH_LVL +: WIDTH_LVL] : olvl_q;
            done_d = !found;
            state_d = found ? EMIT : IDLE;
        end
        if (state_q == EMIT && conf.ready) begin
            pend_d = pend_q & ~(NUM_C'(1) << cid_q);
            valid_d = 1'b0;
            state_d = SCAN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q <= '0;
            lvls_q <= '0;
            valid_q <= 1'b0;
            cid_q <= '0;
            olvl_q <= '0;
            done_q <= 1'b0;
            conflict_q <= 1'b0;
            cnt_q <= '0;
            max_q <= '0;
            all_sat_q <= 1'b0;
            imp_any_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q <= pend_d;
            lvls_q <= lvls_d;
            valid_q <= valid_d;
            cid_q <= cid_d;
            olvl_q <= olvl_d;
            done_q <= done_d;
            conflict_q <= conflict_d;
            cnt_q <= cnt_d;
            max_q <= max_d;
            all_sat_q <= all_sat_d;
            imp_any_q <= imp_any_d;
        end
    end

    assign conf.valid = valid_q;
    assign conf.cid = cid_q;
    assign conf.lvl = olvl_q;
    assign busy_o = state_q != IDLE;
    assign done_o = done_q;
    assign conflict_o = conflict_q;
    assign conflict_cnt_o = cnt_q;
    assign max_conf_lvl_o = max_q;
    assign all_sat_o = all_sat_q;
    assign imp_any_o = imp_any_q;
endmodule

// File: tb/tb_conflict_collector.sv
// tb_conflict_collector: table-driven vectors with a conflict scoreboard plus hand-written corner sequences
module tb_conflict_collector;
    logic clk = 1'b0;
    logic rst, start_i;
    logic [7:0] cvec, ivec, svec;
    logic [127:0] lflat;
    logic busy_o, done_o, conflict_o, all_sat_o, imp_any_o;
    logic [3:0] cnt_o;
    logic [15:0] maxl_o;
    int checks = 0;
    int errors = 0;
    logic [18:0] exp_q[$];

    always #5 clk = ~clk;

    conflict_collector_if #(.WIDTH_CID(3), .WIDTH_LVL(16)) cif ();

    conflict_collector #(.NUM_C(8), .WIDTH_CID(3), .WIDTH_LVL(16)) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .conflict_c_vec_i(cvec), .imp_vec_i(ivec), .csat_vec_i(svec),
        .cmax_lvl_flat_i(lflat), .conf(cif.master),
        .busy_o(busy_o), .done_o(done_o), .conflict_o(conflict_o),
        .conflict_cnt_o(cnt_o), .max_conf_lvl_o(maxl_o),
        .all_sat_o(all_sat_o), .imp_any_o(imp_any_o)
    );

    typedef struct {
        logic [7:0] cv, iv, sv;
        logic [127:0] lv;
        int rmode;
        int e_cnt;
        int e_max;
        bit e_sat, e_imp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, cif.valid}, 0);
        chk({tag, "_cid"}, {29'd0, cif.cid}, 0);
        chk({tag, "_lvl"}, {16'd0, cif.lvl}, 0);
        chk({tag, "_busy"}, {31'd0, busy_o}, 0);
        chk({tag, "_done"}, {31'd0, done_o}, 0);
        chk({tag, "_summary"}, {24'd0, conflict_o, cnt_o, all_sat_o, imp_any_o, 1'b0}, 0);
        chk({tag, "_maxlvl"}, {16'd0, maxl_o}, 0);
    endtask

    task automatic collect(input int rmode, output int cyc, output bit got_done);
        logic [18:0] e;
        cyc = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 300) begin
            if (done_o) got_done = 1'b1;
            else begin
                cif.ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                if (cif.valid && cif.ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_conf: got cid %0d lvl %0h expected none", cif.cid, cif.lvl);
                    end else begin
                        e = exp_q.pop_front();
                        chk("conf_cid", {29'd0, cif.cid}, {29'd0, e[18:16]});
                        chk("conf_lvl", {16'd0, cif.lvl}, {16'd0, e[15:0]});
                    end
                end
                step();
                cyc++;
            end
        end
        cif.ready = 1'b0;
    endtask

    vec_t tv[5];

    initial begin
        int cyc;
        bit got;
        tv[0] = '{8'h00, 8'h04, 8'hFF, {8{16'd9}}, 0, 0, 0, 1'b1, 1'b1};
        tv[1] = '{8'b1001_0010, 8'h00, 8'h00,
                  {16'd5, 16'd100, 16'd100, 16'd7, 16'd100, 16'd100, 16'd3, 16'd100}, 0, 3, 7, 1'b0, 1'b0};
        tv[2] = '{8'hFF, 8'hFF, 8'h7F,
                  {16'd1, 16'hFFFF, 16'h7FFF, 16'd4, 16'd3, 16'd2, 16'h8000, 16'd0}, 1, 8, 32'hFFFF, 1'b0, 1'b1};
        tv[3] = '{8'h21, 8'h10, 8'hFF,
                  {16'd0, 16'd0, 16'd10, 16'd0, 16'd50, 16'd0, 16'd0, 16'd10}, 1, 2, 10, 1'b1, 1'b1};
        tv[4] = '{8'h80, 8'h00, 8'h01, {16'h8000, {7{16'h7FFF}}}, 0, 1, 32'h8000, 1'b0, 1'b0};

        rst = 1'b1;
        start_i = 1'b0;
        cvec = '0;
        ivec = '0;
        svec = '0;
        lflat = '0;
        cif.ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_idle_zero("reset");

        for (int t = 0; t < 5; t++) begin
            cvec = tv[t].cv;
            ivec = tv[t].iv;
            svec = tv[t].sv;
            lflat = tv[t].lv;
            for (int i = 0; i < 8; i++)
                if (tv[t].cv[i]) exp_q.push_back({3'(i), tv[t].lv[i*16 +: 16]});
            pulse_start();
            collect(tv[t].rmode, cyc, got);
            chk("done_seen", {31'd0, got}, 1);
            if (tv[t].rmode == 0) chk("done_latency", cyc, 2 * tv[t].e_cnt + 1);
            chk("queue_empty", exp_q.size(), 0);
            exp_q.delete();
            chk("conflict_o", {31'd0, conflict_o}, {31'd0, tv[t].e_cnt != 0});
            chk("conflict_cnt", {28'd0, cnt_o}, tv[t].e_cnt);
            chk("max_conf_lvl", {16'd0, maxl_o}, tv[t].e_max);
            chk("all_sat", {31'd0, all_sat_o}, {31'd0, tv[t].e_sat});
            chk("imp_any", {31'd0, imp_any_o}, {31'd0, tv[t].e_imp});
            step();
            chk("done_pulse_end", {31'd0, done_o}, 0);
            chk("idle_after", {31'd0, busy_o}, 0);
            chk("summary_hold", {28'd0, cnt_o}, tv[t].e_cnt);
        end

        // backpressure: single conflict held for five cycles
        cvec = 8'h01;
        lflat = {{7{16'd0}}, 16'd2};
        pulse_start();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, cif.valid}, 1);
            chk("bp_cid", {29'd0, cif.cid}, 0);
            chk("bp_lvl", {16'd0, cif.lvl}, 2);
            step();
        end
        cif.ready = 1'b1;
        chk("bp_valid_hs", {31'd0, cif.valid}, 1);
        step();
        cif.ready = 1'b0;
        chk("bp_valid_drop", {31'd0, cif.valid}, 0);
        chk("bp_no_early_done", {31'd0, done_o}, 0);
        step();
        chk("bp_done", {31'd0, done_o}, 1);
        step();
        chk("bp_done_off", {31'd0, done_o}, 0);

        // snapshot isolation and start ignored during EMIT
        cvec = 8'b0000_0100;
        lflat = {{5{16'd0}}, 16'd6, 16'd0, 16'd0};
        pulse_start();
        cvec = 8'hFF;
        lflat = {8{16'hFFFF}};
        step();
        chk("snap_valid", {31'd0, cif.valid}, 1);
        chk("snap_cid", {29'd0, cif.cid}, 2);
        pulse_start();
        chk("snap_emit_hold", {31'd0, cif.valid}, 1);
        chk("snap_cid_hold", {29'd0, cif.cid}, 2);
        chk("snap_cnt", {28'd0, cnt_o}, 1);
        chk("snap_max", {16'd0, maxl_o}, 6);
        cif.ready = 1'b1;
        step();
        cif.ready = 1'b0;
        chk("snap_valid_drop", {31'd0, cif.valid}, 0);
        step();
        chk("snap_done", {31'd0, done_o}, 1);
        chk("snap_no_more", {31'd0, cif.valid}, 0);
        step();
        chk("snap_idle", {31'd0, busy_o}, 0);

        // reset mid-EMIT with ready low
        cvec = 8'h10;
        lflat = {{3{16'd0}}, 16'd9, {4{16'd0}}};
        pulse_start();
        step();
        chk("rst_pre_valid", {31'd0, cif.valid}, 1);
        rst = 1'b1;
        step();
        chk_idle_zero("rst_mid1");
        step();
        chk_idle_zero("rst_mid2");
        rst = 1'b0;
        step();
        chk_idle_zero("rst_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
